// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
//
// Purpose
//   Parametrised UART transmitter. Words arrive over a valid/ready handshake
//   into a small FIFO. They are then serialised onto a single TX line as
//   start bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. When another word is already queued as the last
//   stop bit ends, the next start bit follows on the very next cycle.
//
// Parameters
//   CLOCK_SPEED_MHZ  system clock in MHz
//   BAUD_RATE        line rate in bit/s; CYCLES_PER_BIT = clk_hz / baud (>= 2)
//   DATA_BITS        data bits per frame, 5..9
//   PARITY           0 = none, 1 = odd, 2 = even
//   STOP_BITS        1 or 2
//   FIFO_DEPTH       input FIFO entries, power of two, >= 2
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   data_in     word to send
//   data_valid  producer presents a word on data_in
//   data_ready  FIFO can accept a word (low while rst is high)
//   tx          registered serial output, idle high
//   busy        frame in progress or FIFO non-empty
//   tx_done     one-cycle pulse after the last stop bit completes
//   fifo_count  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLOCK_SPEED_MHZ = 100,
    parameter int BAUD_RATE       = 9600,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // Derived constants. The clock rate is widened before the multiply so
    // that fast clocks cannot overflow a 32-bit intermediate.
    localparam longint CLK_HZ         = longint'(CLOCK_SPEED_MHZ) * 64'd1000000;
    localparam int     CYCLES_PER_BIT = int'(CLK_HZ / longint'(BAUD_RATE));
    // Wide enough for a double-length stop period counted in one run.
    localparam int     CNT_W          = $clog2(2 * CYCLES_PER_BIT);
    localparam int     PTR_W          = $clog2(FIFO_DEPTH);
    localparam int     CW             = PTR_W + 1;
    localparam int     BIT_W          = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IDX_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for a word: odd mode makes the total ones count odd,
    // even mode makes it even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        logic p;
        if (PARITY == 1) begin
            p = ~(^word);
        end else begin
            p = ^word;
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;

    logic                   ready_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_empty_s;
    logic                   cnt_last_s;
    logic [DATA_BITS-1:0]   head_s;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Ready comes from the registered count only, so a pop in the same
    // cycle never reopens a full FIFO early.
    assign ready_s      = !rst && (count_q < CNT_FULL);
    assign push_s       = data_valid && ready_s;
    assign fifo_empty_s = (count_q == '0);
    assign head_s       = mem_q[rd_ptr_q];

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    // The stop phase is counted as one long run of STOP_BITS bit times.
    assign cnt_last_s = (state_q == S_STOP) ? (cnt_q == STOP_LAST)
                                            : (cnt_q == BIT_LAST);

    // State register plus datapath registers and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: bit timing, shifting and FIFO pop decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop_s     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
                    shift_d = head_s;
                    par_d   = parity_bit(head_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_last_s) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_last_s) begin
                    cnt_d   = '0;
                    // Next data bit moves into position 0 of the shifter.
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_last_s) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_last_s) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // Chain straight into the next frame when one is queued.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = S_START;
                        shift_d = head_s;
                        par_d   = parity_bit(head_s);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next value of the registered line and busy flag,
    // derived from the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE) || (count_d != '0);
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign data_ready = ready_s;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
//
// Directed bench for uart_tx_param. Five instances share clock and reset,
// each with a different frame format (10 clocks per bit in all cases):
//   0: 8N1   1: 7 data + even parity   2: 7 data + odd parity
//   3: 8N2   4: 9 data + odd parity
// Expected line waveforms are built from hand-written frame bit vectors.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  valid_s;
    logic [4:0]  ready_s;
    logic [4:0]  tx_s;
    logic [4:0]  busy_s;
    logic [4:0]  done_s;
    logic [8:0]  din_s [5];
    logic [2:0]  cnt_s [5];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Trace of DUT outputs, index k = value after the k-th edge past a reference.
    logic        tx_rec    [0:700];
    logic        done_rec  [0:700];
    logic        busy_rec  [0:700];
    logic        ready_rec [0:700];
    logic [2:0]  cnt_rec   [0:700];

    always #5 clk = ~clk;

    // Free-running cycle counter used to time handshakes.
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .data_in(din_s[0][7:0]), .data_valid(valid_s[0]),
        .data_ready(ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]),
        .tx_done(done_s[0]), .fifo_count(cnt_s[0]));

    uart_tx_param #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .data_in(din_s[1][6:0]), .data_valid(valid_s[1]),
        .data_ready(ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]),
        .tx_done(done_s[1]), .fifo_count(cnt_s[1]));

    uart_tx_param #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(7),
                    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .data_in(din_s[2][6:0]), .data_valid(valid_s[2]),
        .data_ready(ready_s[2]), .tx(tx_s[2]), .busy(busy_s[2]),
        .tx_done(done_s[2]), .fifo_count(cnt_s[2]));

    uart_tx_param #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .data_in(din_s[3][7:0]), .data_valid(valid_s[3]),
        .data_ready(ready_s[3]), .tx(tx_s[3]), .busy(busy_s[3]),
        .tx_done(done_s[3]), .fifo_count(cnt_s[3]));

    uart_tx_param #(.CLOCK_SPEED_MHZ(1), .BAUD_RATE(100000), .DATA_BITS(9),
                    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .data_in(din_s[4]), .data_valid(valid_s[4]),
        .data_ready(ready_s[4]), .tx(tx_s[4]), .busy(busy_s[4]),
        .tx_done(done_s[4]), .fifo_count(cnt_s[4]));

    // Records len cycles of outputs of instance idx at successive falling edges.
    task automatic record(input int idx, input int len);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            tx_rec[k]    = tx_s[idx];
            done_rec[k]  = done_s[idx];
            busy_rec[k]  = busy_s[idx];
            ready_rec[k] = ready_s[idx];
            cnt_rec[k]   = cnt_s[idx];
        end
    endtask

    // Offers one word to instance idx and returns at the falling edge after
    // the accepting rising edge; afterwards data_in carries junk.
    task automatic push(input int idx, input logic [8:0] word);
        int t;
        t = 0;
        din_s[idx]   = word;
        valid_s[idx] = 1'b1;
        while (ready_s[idx] !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout inst=%0d got ready=%b want 1", idx, ready_s[idx]);
        end
        @(posedge clk);
        @(negedge clk);
        valid_s[idx] = 1'b0;
        din_s[idx]   = 9'h1AA;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || done_s[i] !== 1'b0 ||
                cnt_s[i] !== 3'd0 || ready_s[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state inst=%0d got tx=%b busy=%b done=%b cnt=%0d ready=%b want 1 0 0 0 0",
                         i, tx_s[i], busy_s[i], done_s[i], cnt_s[i], ready_s[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ready_s[i] !== 1'b1 || tx_s[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_release inst=%0d got ready=%b tx=%b want 1 1",
                         i, ready_s[i], tx_s[i]);
            end
        end
    endtask

    task automatic test_8n1();
        logic [15:0] fb;
        fb = 16'h0;
        fb[0]   = 1'b0;
        fb[8:1] = 8'h46;
        fb[9]   = 1'b1;
        push(0, 9'h046);
        vectors++;
        if (tx_s[0] !== 1'b1 || cnt_s[0] !== 3'd1 || busy_s[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_accept got tx=%b cnt=%0d busy=%b want 1 1 1", tx_s[0], cnt_s[0], busy_s[0]);
        end
        record(0, 102);
        for (int k = 1; k <= 100; k++) begin
            vectors++;
            if (tx_rec[k] !== fb[(k-1)/CPB]) begin
                miscompares++;
                $display("FAIL t1_tx k=%0d got %b want %b", k, tx_rec[k], fb[(k-1)/CPB]);
            end
        end
        for (int k = 1; k <= 102; k++) begin
            vectors++;
            if (done_rec[k] !== (k == 101)) begin
                miscompares++;
                $display("FAIL t1_done k=%0d got %b want %b", k, done_rec[k], (k == 101));
            end
        end
        vectors++;
        if (busy_rec[100] !== 1'b1 || busy_rec[101] !== 1'b0 || tx_rec[101] !== 1'b1 || cnt_rec[1] !== 3'd0) begin
            miscompares++;
            $display("FAIL t1_end got busy100=%b busy101=%b tx101=%b cnt1=%0d want 1 0 1 0",
                     busy_rec[100], busy_rec[101], tx_rec[101], cnt_rec[1]);
        end
    endtask

    task automatic test_parity();
        logic [15:0] fb;
        logic        par;
        for (int idx = 1; idx <= 2; idx++) begin
            // 0x41 has two ones: even mode gives 0, odd mode gives 1.
            par = (idx == 2) ? 1'b1 : 1'b0;
            fb = 16'h0;
            fb[0]   = 1'b0;
            fb[7:1] = 7'h41;
            fb[8]   = par;
            fb[9]   = 1'b1;
            push(idx, 9'h041);
            record(idx, 102);
            vectors++;
            if (tx_rec[85] !== par) begin
                miscompares++;
                $display("FAIL t2_parity inst=%0d got %b want %b", idx, tx_rec[85], par);
            end
            for (int k = 1; k <= 100; k++) begin
                vectors++;
                if (tx_rec[k] !== fb[(k-1)/CPB]) begin
                    miscompares++;
                    $display("FAIL t2_tx inst=%0d k=%0d got %b want %b", idx, k, tx_rec[k], fb[(k-1)/CPB]);
                end
            end
            for (int k = 1; k <= 102; k++) begin
                vectors++;
                if (done_rec[k] !== (k == 101)) begin
                    miscompares++;
                    $display("FAIL t2_done inst=%0d k=%0d got %b want %b", idx, k, done_rec[k], (k == 101));
                end
            end
        end
    endtask

    task automatic test_two_stop();
        logic [15:0] fb;
        fb = 16'h0;
        fb[0]    = 1'b0;
        fb[8:1]  = 8'h55;
        fb[10:9] = 2'b11;
        push(3, 9'h055);
        record(3, 112);
        for (int k = 1; k <= 110; k++) begin
            vectors++;
            if (tx_rec[k] !== fb[(k-1)/CPB]) begin
                miscompares++;
                $display("FAIL t3_tx k=%0d got %b want %b", k, tx_rec[k], fb[(k-1)/CPB]);
            end
        end
        for (int k = 1; k <= 112; k++) begin
            vectors++;
            if (done_rec[k] !== (k == 111)) begin
                miscompares++;
                $display("FAIL t3_done k=%0d got %b want %b", k, done_rec[k], (k == 111));
            end
        end
        vectors++;
        if (busy_rec[110] !== 1'b1 || busy_rec[111] !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_busy got %b %b want 1 0", busy_rec[110], busy_rec[111]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] fb;
        int          acc [2:6];
        int          base;
        int          j;
        int          t;
        push(0, 9'h001);
        base = cyc;
        fork
            record(0, 603);
            begin
                for (int i = 2; i <= 6; i++) begin
                    t = 0;
                    din_s[0]   = 9'(i);
                    valid_s[0] = 1'b1;
                    while (ready_s[0] !== 1'b1 && t < 300) begin
                        @(negedge clk);
                        t++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    acc[i] = cyc - base;
                end
                valid_s[0] = 1'b0;
                din_s[0]   = 9'h0FF;
            end
        join
        // Words 2..5 enter on the next four edges; word 6 waits for the
        // first frame to finish (pop at edge 101), entering at edge 102.
        vectors++;
        if (acc[2] !== 1 || acc[5] !== 4 || acc[6] !== 102) begin
            miscompares++;
            $display("FAIL t4_accept got %0d %0d %0d want 1 4 102", acc[2], acc[5], acc[6]);
        end
        vectors++;
        if (cnt_rec[3] !== 3'd3 || cnt_rec[4] !== 3'd4 || ready_rec[4] !== 1'b0 ||
            ready_rec[100] !== 1'b0 || ready_rec[101] !== 1'b1 || cnt_rec[102] !== 3'd4) begin
            miscompares++;
            $display("FAIL t4_full got c3=%0d c4=%0d r4=%b r100=%b r101=%b c102=%0d want 3 4 0 0 1 4",
                     cnt_rec[3], cnt_rec[4], ready_rec[4], ready_rec[100], ready_rec[101], cnt_rec[102]);
        end
        for (int k = 1; k <= 600; k++) begin
            j = (k - 1) / 100;
            fb = 16'h0;
            fb[8:1] = 8'(j + 1);
            fb[9]   = 1'b1;
            vectors++;
            if (tx_rec[k] !== fb[((k-1)%100)/CPB]) begin
                miscompares++;
                $display("FAIL t4_tx k=%0d frame=%0d got %b want %b", k, j, tx_rec[k], fb[((k-1)%100)/CPB]);
            end
        end
        for (int k = 1; k <= 603; k++) begin
            vectors++;
            if (done_rec[k] !== (k > 100 && k <= 601 && ((k - 1) % 100) == 0)) begin
                miscompares++;
                $display("FAIL t4_done k=%0d got %b", k, done_rec[k]);
            end
        end
        vectors++;
        if (busy_rec[600] !== 1'b1 || busy_rec[601] !== 1'b0 || cnt_rec[601] !== 3'd0 || tx_rec[602] !== 1'b1) begin
            miscompares++;
            $display("FAIL t4_end got busy600=%b busy601=%b cnt=%0d tx=%b want 1 0 0 1",
                     busy_rec[600], busy_rec[601], cnt_rec[601], tx_rec[602]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] fb;
        push(0, 9'h0A5);
        push(0, 9'h011);
        push(0, 9'h022);
        // Now two cycles past the first accept; step into data bit 3.
        repeat (43) @(negedge clk);
        vectors++;
        if (tx_s[0] !== 1'b0 || cnt_s[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL t5_before got tx=%b cnt=%0d want 0 2", tx_s[0], cnt_s[0]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (tx_s[0] !== 1'b1 || cnt_s[0] !== 3'd0 || busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_reset got tx=%b cnt=%0d busy=%b ready=%b want 1 0 0 0",
                     tx_s[0], cnt_s[0], busy_s[0], ready_s[0]);
        end
        rst = 1'b0;
        record(0, 20);
        for (int k = 1; k <= 20; k++) begin
            vectors++;
            if (tx_rec[k] !== 1'b1 || busy_rec[k] !== 1'b0 || cnt_rec[k] !== 3'd0) begin
                miscompares++;
                $display("FAIL t5_quiet k=%0d got tx=%b busy=%b cnt=%0d want 1 0 0",
                         k, tx_rec[k], busy_rec[k], cnt_rec[k]);
            end
        end
        fb = 16'h0;
        fb[8:1] = 8'h3C;
        fb[9]   = 1'b1;
        push(0, 9'h03C);
        record(0, 102);
        for (int k = 1; k <= 100; k++) begin
            vectors++;
            if (tx_rec[k] !== fb[(k-1)/CPB]) begin
                miscompares++;
                $display("FAIL t5_tx k=%0d got %b want %b", k, tx_rec[k], fb[(k-1)/CPB]);
            end
        end
        vectors++;
        if (done_rec[100] !== 1'b0 || done_rec[101] !== 1'b1 || busy_rec[101] !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_done got d100=%b d101=%b busy=%b want 0 1 0",
                     done_rec[100], done_rec[101], busy_rec[101]);
        end
    endtask

    task automatic test_nine_bit();
        logic [15:0] fb;
        // Nine ones already odd, so the odd-parity bit is 0.
        fb = 16'h0;
        fb[9:1] = 9'h1FF;
        fb[10]  = 1'b0;
        fb[11]  = 1'b1;
        push(4, 9'h1FF);
        record(4, 122);
        for (int k = 1; k <= 120; k++) begin
            vectors++;
            if (tx_rec[k] !== fb[(k-1)/CPB]) begin
                miscompares++;
                $display("FAIL t6_tx k=%0d got %b want %b", k, tx_rec[k], fb[(k-1)/CPB]);
            end
        end
        for (int k = 1; k <= 122; k++) begin
            vectors++;
            if (done_rec[k] !== (k == 121)) begin
                miscompares++;
                $display("FAIL t6_done k=%0d got %b want %b", k, done_rec[k], (k == 121));
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_s = 5'b0;
        for (int i = 0; i < 5; i++) din_s[i] = 9'h000;
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_nine_bit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised successor to the single-byte UART sender.
- Serialises words from a small internal FIFO onto one TX line.
- Data width, parity mode, stop-bit count, baud rate and FIFO depth are all configurable.
- Sits between any byte/word producer (display controller, debug logger) and the board TX pin, with a valid/ready input handshake and back-to-back frame transmission.

Parameters:
- CLOCK_SPEED_MHZ, 100, system clock frequency in MHz.
- BAUD_RATE, 9600, line rate in bit/s. CYCLES_PER_BIT = CLOCK_SPEED_MHZ*1e6/BAUD_RATE, truncated, must be ≥2.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries, power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  DATA_BITS  word to send.
- data_valid  input  1  producer has a word on data_in.
- data_ready  output  1  FIFO can accept; a transfer happens on an edge where data_valid && data_ready.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at an edge):
  - tx=1, busy=0, tx_done=0, fifo_count=0; FIFO flushed; state IDLE.
  - data_ready is 0 while rst is high.
  - Reset mid-frame abandons the frame: tx is high after that edge, and no partial frame resumes.
- Handshake and FIFO:
  - data_ready = !rst && fifo_count < FIFO_DEPTH, derived from registered count.
  - When full, data_ready stays low even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - data_in is ignored when the handshake does not complete.
  - Order is strictly FIFO.
- State machine (IDLE, START, DATA, PARITY, STOP), with one bit-cycle counter running 0..CYCLES_PER_BIT-1:
  - IDLE: tx=1. If the FIFO is non-empty, on that edge pop the head into the shift register, go to START, clear the counter, and drive tx=0.
  - START: after CYCLES_PER_BIT cycles go to DATA, bit index 0, tx = data[0].
  - DATA: bits are sent LSB first, each held exactly CYCLES_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: odd mode makes the total ones in data+parity odd; even mode makes it even. Held for one bit time.
  - STOP: tx=1 for STOP_BITS*CYCLES_PER_BIT cycles. On the final edge, assert tx_done for one cycle. Then:
    - if the FIFO is non-empty, pop and go directly to START (tx=0, zero idle cycles between frames);
    - otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CYCLES_PER_BIT cycles exactly.
- Latency: word accepted into an empty FIFO while IDLE at edge N → pop at edge N+1 → tx low from edge N+1.
- Counter width: ≥ $clog2(2*CYCLES_PER_BIT) bits, with no wrap before the terminal count.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
(All use CLOCK_SPEED_MHZ=1, BAUD_RATE=100000, so CYCLES_PER_BIT=10.)
1. Defaults 8N1: send 0x46 → tx low 10 cycles starting 1 cycle after accept; data bits 0,1,1,0,0,0,1,0 at 10 cycles each; stop high 10 cycles; tx_done pulses once exactly 100 cycles after tx falls; busy then drops.
2. DATA_BITS=7, send 0x41:
   - PARITY=2 → parity bit 0.
   - PARITY=1 → parity bit 1.
   - In both cases frame = 100 cycles and the stop bit is high.
3. STOP_BITS=2, PARITY=0, send 0x55 → stop high for 20 cycles; frame 110 cycles; tx_done at end of cycle 110.
4. FIFO_DEPTH=4, data_valid held high with words 0x01..0x06:
   - first word popped immediately; fifo_count reaches 4 and data_ready drops;
   - remaining words are accepted one per frame completion;
   - six frames go out back-to-back with no idle-high gap, in order 0x01..0x06.
5. Reset pulsed during data bit 3 of 0xA5 with 2 words queued → tx=1, fifo_count=0, busy=0 the next cycle. A new word 0x3C after reset transmits cleanly with the correct frame.
6. DATA_BITS=9, PARITY=1, send 0x1FF → nine ones, parity bit 0; frame 120 cycles; 9-bit data_in is fully serialised LSB first.
